// File: rtl/var_bw_div_if.sv
// Valid/ready operand and result bundle for var_bw_div.
interface var_bw_div_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             para_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;

    modport master (
        output in_valid, para_mode, a, b, out_ready,
        input  in_ready, out_valid, q, r
    );

    modport slave (
        input  in_valid, para_mode, a, b, out_ready,
        output in_ready, out_valid, q, r
    );
endinterface

// File: rtl/var_bw_div.sv
// Iterative restoring divider: one WIDTH-bit or two WIDTH/2-bit lanes.
// Optional VAR_BW_DIV_DBZ_EN adds a registered per-lane divide-by-zero flag.
module var_bw_div #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    var_bw_div_if.slave bus
`ifdef VAR_BW_DIV_DBZ_EN
    ,
    output logic [1:0]  dbz
`endif
);
    localparam int H  = WIDTH / 2;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic             mode;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] dvd_n;
    logic             last;

    logic [WIDTH:0]   sh_f;
    logic [WIDTH-1:0] df_f;
    logic             ge_f;
    logic [H:0]       sh_h;
    logic [H-1:0]     df_h;
    logic             ge_h;
    logic [H:0]       sh_l;
    logic [H-1:0]     df_l;
    logic             ge_l;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign last          = (cnt == CW'(1));

    // Quotient bits shift into the low end of dvd as the dividend shifts out.
    always_comb begin
        sh_f = {rem, dvd[WIDTH-1]};
        ge_f = (sh_f >= {1'b0, dvs});
        df_f = sh_f[WIDTH-1:0] - dvs;
        sh_h = {rem[WIDTH-1:H], dvd[WIDTH-1]};
        ge_h = (sh_h >= {1'b0, dvs[WIDTH-1:H]});
        df_h = sh_h[H-1:0] - dvs[WIDTH-1:H];
        sh_l = {rem[H-1:0], dvd[H-1]};
        ge_l = (sh_l >= {1'b0, dvs[H-1:0]});
        df_l = sh_l[H-1:0] - dvs[H-1:0];
        if (mode) begin
            rem_n = {ge_h ? df_h : sh_h[H-1:0],
                     ge_l ? df_l : sh_l[H-1:0]};
            dvd_n = {dvd[WIDTH-2:H], ge_h, dvd[H-2:0], ge_l};
        end else begin
            rem_n = ge_f ? df_f : sh_f[WIDTH-1:0];
            dvd_n = {dvd[WIDTH-2:0], ge_f};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  state_n = BUSY;
            BUSY:    if (last)          state_n = DONE;
            DONE:    if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            mode  <= 1'b0;
            rem   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            bus.q <= '0;
            bus.r <= '0;
`ifdef VAR_BW_DIV_DBZ_EN
            dbz   <= 2'b00;
`endif
        end else begin
            if (state == IDLE && bus.in_valid) begin
                dvd  <= bus.a;
                dvs  <= bus.b;
                mode <= bus.para_mode;
                rem  <= '0;
                cnt  <= bus.para_mode ? CW'(H) : CW'(WIDTH);
            end
            if (state == BUSY) begin
                rem <= rem_n;
                dvd <= dvd_n;
                cnt <= cnt - CW'(1);
                if (last) begin
                    bus.q <= dvd_n;
                    bus.r <= rem_n;
`ifdef VAR_BW_DIV_DBZ_EN
                    dbz <= mode ? {dvs[WIDTH-1:H] == '0, dvs[H-1:0] == '0}
                                : {2{dvs == '0}};
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_var_bw_div.sv
// Directed scoreboard bench for var_bw_div (full, para, dbz, backpressure, reset).
module tb_var_bw_div;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    var_bw_div_if #(.WIDTH(W)) bus ();
`ifdef VAR_BW_DIV_DBZ_EN
    logic [1:0] dbz;
`endif

    var_bw_div #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef VAR_BW_DIV_DBZ_EN
        ,
        .dbz(dbz)
`endif
    );

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic [1:0]  z;
        int          n;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int prev_acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] q, input logic [15:0] r,
                                input logic [1:0] z, input int n);
        exp_t e;
        e.q = q; e.r = r; e.z = z; e.n = n;
        return e;
    endfunction

    // Reference: plain / and % per lane; zero divisor gives all-ones, dividend.
    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                   input logic m);
        exp_t e;
        logic [7:0] ah, al, bh, bl;
        if (!m) begin
            e.q = (bv == 0) ? 16'hFFFF : av / bv;
            e.r = (bv == 0) ? av : av % bv;
            e.z = {2{bv == 0}};
            e.n = 16;
        end else begin
            ah = av[15:8]; al = av[7:0]; bh = bv[15:8]; bl = bv[7:0];
            e.q[15:8] = (bh == 0) ? 8'hFF : ah / bh;
            e.r[15:8] = (bh == 0) ? ah : ah % bh;
            e.q[7:0]  = (bl == 0) ? 8'hFF : al / bl;
            e.r[7:0]  = (bl == 0) ? al : al % bl;
            e.z = {bh == 0, bl == 0};
            e.n = 8;
        end
        return e;
    endfunction

    task automatic send(input logic [15:0] av, input logic [15:0] bv,
                        input logic m, input exp_t e, input bit push);
        int k = 0;
        while (!bus.in_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        check("in_ready_wait", bus.in_ready, 1);
        bus.a = av; bus.b = bv; bus.para_mode = m; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        bus.para_mode = ~m;
        if (push) sb.push_back(e);
    endtask

    task automatic recv(input string tag, input int hold);
        exp_t e;
        logic [15:0] q0, r0;
        int k = 0;
        while (!bus.out_valid && k < 40) begin
            check({tag, "_busy_ready"}, bus.in_ready, 0);
            @(posedge clk); #1; k++;
        end
        check({tag, "_valid"}, bus.out_valid, 1);
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, cyc - acc_cyc, e.n);
        check({tag, "_q"}, bus.q, e.q);
        check({tag, "_r"}, bus.r, e.r);
`ifdef VAR_BW_DIV_DBZ_EN
        check({tag, "_dbz"}, dbz, e.z);
`endif
        q0 = bus.q; r0 = bus.r;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, bus.out_valid, 1);
            check({tag, "_hold_ready"}, bus.in_ready, 0);
            check({tag, "_hold_q"}, bus.q, q0);
            check({tag, "_hold_r"}, bus.r, r0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_idle_ready"}, bus.in_ready, 1);
        check({tag, "_idle_valid"}, bus.out_valid, 0);
        check({tag, "_keep_q"}, bus.q, e.q);
    endtask

    initial begin
        exp_t e;
        logic [15:0] ra, rb;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.para_mode = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_q", bus.q, 0);
        check("rst_r", bus.r, 0);
`ifdef VAR_BW_DIV_DBZ_EN
        check("rst_dbz", dbz, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        send(16'h03E8, 16'h0007, 1'b0, mk(16'h008E, 16'h0006, 2'b00, 16), 1);
        recv("full", 0);
        send(16'hC864, 16'h0D07, 1'b1, mk(16'h0F0E, 16'h0502, 2'b00, 8), 1);
        recv("para", 0);
        send(16'h1234, 16'h0000, 1'b0, mk(16'hFFFF, 16'h1234, 2'b11, 16), 1);
        recv("dbz_full", 0);
        send(16'h5040, 16'h0003, 1'b1, mk(16'hFF15, 16'h5001, 2'b10, 8), 1);
        recv("dbz_para", 0);

        send(16'h2710, 16'h0031, 1'b0, mk(16'h00CC, 16'h0004, 2'b00, 16), 1);
        recv("bp", 5);
        @(posedge clk); #1;
        check("bp_no_accept", bus.in_ready, 1);

        send(16'hBEEF, 16'h0123, 1'b0, mk(16'h0, 16'h0, 2'b00, 16), 0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_valid", bus.out_valid, 0);
        check("rst_mid_q", bus.q, 0);
        check("rst_mid_r", bus.r, 0);
        check("rst_mid_ready", bus.in_ready, 1);
        send(16'h6409, 16'h0A02, 1'b1, mk(16'h0A04, 16'h0001, 2'b00, 8), 1);
        recv("post_rst", 0);

        send(16'hFFFF, 16'h0001, 1'b0, mk(16'hFFFF, 16'h0000, 2'b00, 16), 1);
        recv("ext1", 0);
        prev_acc = acc_cyc;
        send(16'hFFFE, 16'hFFFF, 1'b0, mk(16'h0000, 16'hFFFE, 2'b00, 16), 1);
        check("b2b_interval", acc_cyc - prev_acc, 18);
        recv("ext2", 0);

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom_range(0, 300));
            e = model(ra, rb, 1'(i % 2));
            prev_acc = acc_cyc;
            send(ra, rb, 1'(i % 2), e, 1);
            recv("rand", 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
